// File: rtl/chunked_serial_adder_pkg.sv
// Shared definitions for the chunked serial adder.
//   state_t        : controller states (IDLE, RUN)
//   num_chunks     : number of CHUNK-wide slices in a WIDTH-bit operand
//   cnt_width      : bits needed by the chunk counter, never less than 1
//   chunking_valid : elaboration-time legality test for WIDTH/CHUNK
package chunked_serial_adder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int num_chunks(input int width, input int chunk);
      return width / chunk;
   endfunction

   function automatic int cnt_width(input int width, input int chunk);
      int n;
      n = num_chunks(width, chunk);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic bit chunking_valid(input int width, input int chunk);
      return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/chunked_serial_adder_if.sv
// Operation bus of the chunked serial adder.
// Handshake: the master raises start with sub/c_in/a/b valid; the slave
// accepts it on any rising edge where busy=0 (busy=0 is the "ready"). A
// start seen while busy=1 is dropped, never queued. Completion is signalled
// by a one-cycle done pulse; sum/c_out/overflow then hold until the next
// completion.
//   start, sub, c_in, a, b          : master -> slave request
//   busy, done, sum, c_out, overflow: slave -> master status/result
interface chunked_serial_adder_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             sub;
   logic             c_in;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             overflow;

   modport master (
      output start, sub, c_in, a, b,
      input  busy, done, sum, c_out, overflow
   );

   modport slave (
      input  start, sub, c_in, a, b,
      output busy, done, sum, c_out, overflow
   );
endinterface

// File: rtl/chunked_serial_adder_ripple_chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from a chain of 1-bit
// full-adder cells.
//   a, b     : CHUNK-bit addends
//   cin      : carry into bit 0
//   s        : CHUNK-bit sum
//   cout     : carry out of the top bit
//   c_msb_in : carry into the top bit (used for signed overflow)
module ripple_chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             c_msb_in
);

   // Each cell owns its carry nets so the chain is a set of distinct
   // signals rather than one vector feeding back on itself.
   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      logic ci;
      logic co;
      if (i == 0) begin : g_first
         assign ci = cin;
      end else begin : g_rest
         assign ci = g_fa[i-1].co;
      end
      assign s[i] = a[i] ^ b[i] ^ ci;
      assign co   = (a[i] & b[i]) | (ci & (a[i] ^ b[i]));
   end

   assign cout     = g_fa[CHUNK-1].co;
   assign c_msb_in = g_fa[CHUNK-1].ci;

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor processing CHUNK bits per clock, with the
// inter-chunk carry held in a register.
//   clk       : rising-edge clock
//   reset     : asynchronous active-high reset
//   bus       : slave side of chunked_serial_adder_if (start/sub/c_in/a/b
//               in, busy/done/sum/c_out/overflow out)
//   dbg_state : current controller state
module chunked_serial_adder
   import chunked_serial_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   chunked_serial_adder_if.slave  bus,
   output state_t                 dbg_state
);

   localparam int N  = num_chunks(WIDTH, CHUNK);
   localparam int CW = cnt_width(WIDTH, CHUNK);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if (!chunking_valid(WIDTH, CHUNK)) begin : g_bad_chunking
      $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
   end

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] res;
   logic             carry;

   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             c_out_q;
   logic             overflow_q;

   logic [CHUNK-1:0] slice_a;
   logic [CHUNK-1:0] slice_b;
   logic [CHUNK-1:0] slice_s;
   logic             cy;
   logic             c_top;
   logic [WIDTH-1:0] res_next;
   int               base;

   // Operand slice selected by the chunk counter.
   always_comb begin
      base    = int'(cnt) * CHUNK;
      slice_a = op_a[base +: CHUNK];
      slice_b = op_b[base +: CHUNK];
   end

   ripple_chunk_adder #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .a        (slice_a),
      .b        (slice_b),
      .cin      (carry),
      .s        (slice_s),
      .cout     (cy),
      .c_msb_in (c_top)
   );

   // Result with the current slice merged in; on the last chunk this is
   // the complete result that goes to sum.
   always_comb begin
      res_next = res;
      res_next[int'(cnt) * CHUNK +: CHUNK] = slice_s;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         op_a       <= '0;
         op_b       <= '0;
         res        <= '0;
         carry      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         sum_q      <= '0;
         c_out_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  // Subtraction is a + ~b + 1: invert B and force carry-in.
                  op_a   <= bus.a;
                  op_b   <= bus.sub ? ~bus.b : bus.b;
                  carry  <= bus.sub ? 1'b1 : bus.c_in;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               res   <= res_next;
               carry <= cy;
               if (cnt == LAST) begin
                  // The last chunk holds bit WIDTH-1, so c_top is the
                  // carry into the MSB.
                  sum_q      <= res_next;
                  c_out_q    <= cy;
                  overflow_q <= c_top ^ cy;
                  done_q     <= 1'b1;
                  busy_q     <= 1'b0;
                  cnt        <= '0;
                  state      <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.sum      = sum_q;
   assign bus.c_out    = c_out_q;
   assign bus.overflow = overflow_q;
   assign dbg_state    = state;

endmodule
